timing_param_sequencer: RTL and testbench

//  Owns the programmable timing parameters of the traffic light controller and sequences the interval timer.

---
 rtl/tlc_timing_pkg.sv | 29 ++
 rtl/tick_gen.sv | 40 ++++
 rtl/timing_param_sequencer.sv | 118 +++++++++++
 tb/tb_timing_param_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tlc_timing_pkg.sv
// rtl/tlc_timing_pkg.sv - shared codes and defaults for the traffic light timing sequencer
package tlc_timing_pkg;

    typedef enum logic [1:0] {
        SEL_BASE = 2'b00,
        SEL_EXT  = 2'b01,
        SEL_YEL  = 2'b10,
        SEL_RSVD = 2'b11
    } param_sel_e;

    typedef enum logic [1:0] {
        INT_BASE   = 2'b00,
        INT_EXT    = 2'b01,
        INT_YEL    = 2'b10,
        INT_DOUBLE = 2'b11
    } interval_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } timer_state_e;

    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_VAL_W   = 4;
    localparam int DEF_T_BASE  = 6;
    localparam int DEF_T_EXT   = 3;
    localparam int DEF_T_YEL   = 2;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running seconds divider with synchronous clear and registered tick
module tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic wrap_o,
    output logic tick_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    // wrap_o is the combinational "this edge ends a second"; tick_o is the same event, registered
    assign wrap_o = (div_q == DW'(CLK_DIV - 1));
    assign tick_o = tick_q;

    always_comb begin
        div_d  = wrap_o ? '0 : div_q + DW'(1);
        tick_d = wrap_o;
        if (clear_i) begin
            div_d  = '0;
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/timing_param_sequencer.sv
// rtl/timing_param_sequencer.sv - programmable timing parameters and interval timer for the traffic controller
module timing_param_sequencer
    import tlc_timing_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int VAL_W      = DEF_VAL_W,
    parameter int T_BASE_DEF = DEF_T_BASE,
    parameter int T_EXT_DEF  = DEF_T_EXT,
    parameter int T_YEL_DEF  = DEF_T_YEL
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reprogram,
    input  logic [1:0]       time_param_selector,
    input  logic [VAL_W-1:0] time_value,
    input  logic             start_timer,
    input  logic [1:0]       interval_sel,
    output logic             expired,
    output logic             enable_tick,
    output logic             busy,
    output logic [VAL_W:0]   remaining,
    output logic             reprog_ack,
    output logic             fsm_restart
);

    timer_state_e     state_q, state_d;
    logic [VAL_W-1:0] t_base_q, t_base_d, t_ext_q, t_ext_d, t_yel_q, t_yel_d;
    logic [VAL_W:0]   remaining_q, remaining_d, n_sel;
    logic             expired_q, expired_d, ack_q, ack_d, restart_q, restart_d;
    logic             wrap, tick_clear, write_ok;
    logic [VAL_W-1:0] wr_val;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (tick_clear),
        .wrap_o  (wrap),
        .tick_o  (enable_tick)
    );

    assign write_ok = reprogram && (time_param_selector != SEL_RSVD);
    // A zero interval would never expire, so it is stored as one second
    assign wr_val   = (time_value == '0) ? VAL_W'(1) : time_value;

    always_comb begin
        case (interval_sel)
            INT_BASE: n_sel = {1'b0, t_base_q};
            INT_EXT:  n_sel = {1'b0, t_ext_q};
            INT_YEL:  n_sel = {1'b0, t_yel_q};
            default:  n_sel = {t_base_q, 1'b0};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        ack_d       = 1'b0;
        restart_d   = 1'b0;
        tick_clear  = 1'b0;
        t_base_d    = t_base_q;
        t_ext_d     = t_ext_q;
        t_yel_d     = t_yel_q;
        // Priority: valid write aborts everything, then (re)start, then the running count
        if (write_ok) begin
            case (time_param_selector)
                SEL_BASE: t_base_d = wr_val;
                SEL_EXT:  t_ext_d  = wr_val;
                default:  t_yel_d  = wr_val;
            endcase
            ack_d       = 1'b1;
            restart_d   = 1'b1;
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else if (start_timer) begin
            state_d     = ST_COUNT;
            remaining_d = n_sel;
            tick_clear  = 1'b1;
        end else if (state_q == ST_COUNT && wrap) begin
            if (remaining_q == (VAL_W+1)'(1)) begin
                state_d     = ST_IDLE;
                remaining_d = '0;
                expired_d   = 1'b1;
            end else begin
                remaining_d = remaining_q - (VAL_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            ack_q       <= 1'b0;
            restart_q   <= 1'b0;
            t_base_q    <= VAL_W'(T_BASE_DEF);
            t_ext_q     <= VAL_W'(T_EXT_DEF);
            t_yel_q     <= VAL_W'(T_YEL_DEF);
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            ack_q       <= ack_d;
            restart_q   <= restart_d;
            t_base_q    <= t_base_d;
            t_ext_q     <= t_ext_d;
            t_yel_q     <= t_yel_d;
        end
    end

    assign busy        = (state_q == ST_COUNT);
    assign remaining   = remaining_q;
    assign expired     = expired_q;
    assign reprog_ack  = ack_q;
    assign fsm_restart = restart_q;

endmodule

// File: tb/tb_timing_param_sequencer.sv
// tb/tb_timing_param_sequencer.sv - directed and randomized self-checking bench for timing_param_sequencer
module tb_timing_param_sequencer;

    localparam int CLK_DIV = 4;
    localparam int VAL_W   = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             reprogram;
    logic [1:0]       time_param_selector;
    logic [VAL_W-1:0] time_value;
    logic             start_timer;
    logic [1:0]       interval_sel;
    logic             expired, enable_tick, busy, reprog_ack, fsm_restart;
    logic [VAL_W:0]   remaining;

    int checks = 0;
    int errors = 0;

    // Reference model: time-based view (edge index, start edge, interval length)
    int e, s, clr, n_len;
    bit active;
    int prm [3];
    int m_exp, m_tick, m_busy, m_rem, m_ack, m_rst;

    timing_param_sequencer #(
        .CLK_DIV(CLK_DIV), .VAL_W(VAL_W), .T_BASE_DEF(6), .T_EXT_DEF(3), .T_YEL_DEF(2)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .reprogram           (reprogram),
        .time_param_selector (time_param_selector),
        .time_value          (time_value),
        .start_timer         (start_timer),
        .interval_sel        (interval_sel),
        .expired             (expired),
        .enable_tick         (enable_tick),
        .busy                (busy),
        .remaining           (remaining),
        .reprog_ack          (reprog_ack),
        .fsm_restart         (fsm_restart)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d at edge %0d", tag, obs, expv, e);
        end
    endtask

    task automatic model_reset();
        e = 0; clr = 0; s = 0; n_len = 0; active = 0;
        prm[0] = 6; prm[1] = 3; prm[2] = 2;
    endtask

    task automatic check_all();
        chk("expired", expired, m_exp);
        chk("enable_tick", enable_tick, m_tick);
        chk("busy", busy, m_busy);
        chk("remaining", remaining, m_rem);
        chk("reprog_ack", reprog_ack, m_ack);
        chk("fsm_restart", fsm_restart, m_rst);
    endtask

    task automatic step(input bit rp, input logic [1:0] sel, input logic [3:0] val,
                        input bit st, input logic [1:0] isel);
        bit wr;
        reprogram = rp; time_param_selector = sel; time_value = val;
        start_timer = st; interval_sel = isel;
        @(posedge clock);
        e++;
        wr = rp && (sel != 2'b11);
        m_ack = int'(wr); m_rst = int'(wr); m_exp = 0;
        if (wr) begin
            prm[sel] = (val == 0) ? 1 : int'(val);
            active = 0;
        end else if (st) begin
            n_len = (isel == 2'b11) ? 2 * prm[0] : prm[isel];
            active = 1; s = e; clr = e;
        end else if (active && (e - s) == n_len * CLK_DIV) begin
            active = 0; m_exp = 1;
        end
        m_tick = int'((e != clr) && ((e - clr) % CLK_DIV == 0));
        m_busy = int'(active);
        m_rem  = active ? n_len - (e - s) / CLK_DIV : 0;
        #1;
        reprogram = 1'b0; start_timer = 1'b0;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 4'd0, 1'b0, 2'b00);
    endtask

    task automatic run_until_expired(input string tag, input int want);
        int lat = -1;
        for (int i = 1; i <= 100; i++) begin
            idle();
            if (expired === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk(tag, lat, want);
    endtask

    initial begin
        model_reset();
        reset = 1'b0; reprogram = 1'b0; time_param_selector = 2'b00; time_value = '0;
        start_timer = 1'b0; interval_sel = 2'b00;
        m_exp = 0; m_tick = 0; m_busy = 0; m_rem = 0; m_ack = 0; m_rst = 0;
        repeat (3) @(posedge clock);
        #1;
        check_all();
        #3 reset = 1'b1;

        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b00);
        chk("start_base_busy", busy, 1);
        chk("start_base_rem", remaining, 6);
        run_until_expired("lat_base", 24);
        idle();

        step(1'b1, 2'b10, 4'd5, 1'b0, 2'b00);
        chk("wr_yel_ack", reprog_ack, 1);
        chk("wr_yel_restart", fsm_restart, 1);
        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b10);
        run_until_expired("lat_yel5", 20);
        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b01);
        run_until_expired("lat_ext_after_expire", 12);

        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b01);
        repeat (5) idle();
        step(1'b1, 2'b00, 4'd0, 1'b0, 2'b00);
        chk("abort_busy", busy, 0);
        repeat (14) idle();
        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b00);
        run_until_expired("lat_base_clamped", 4);

        step(1'b1, 2'b00, 4'd6, 1'b0, 2'b00);
        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b00);
        repeat (9) idle();
        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b01);
        run_until_expired("lat_retrigger", 12);

        step(1'b1, 2'b11, 4'd9, 1'b0, 2'b00);
        chk("rsvd_no_ack", reprog_ack, 0);
        chk("rsvd_no_restart", fsm_restart, 0);
        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b11);
        run_until_expired("lat_double_base", 48);

        step(1'b1, 2'b01, 4'd3, 1'b1, 2'b00);
        chk("wr_beats_start", busy, 0);
        step(1'b1, 2'b11, 4'd1, 1'b1, 2'b01);
        chk("rsvd_start_honoured", busy, 1);
        repeat (3) idle();

        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b00);
        repeat (7) idle();
        #3 reset = 1'b0;
        #1;
        chk("rst_expired", expired, 0);
        chk("rst_tick", enable_tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rem", remaining, 0);
        chk("rst_ack", reprog_ack, 0);
        chk("rst_restart", fsm_restart, 0);
        #3 reset = 1'b1;
        model_reset();
        repeat (30) idle();
        step(1'b0, 2'b00, 4'd0, 1'b1, 2'b10);
        run_until_expired("lat_yel_default", 8);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 14) == 0, 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
